pwm_duty_capture: RTL and testbench

//   Receive-side counterpart of the RGB PWM fade driver. Samples the three PWM lines
//   (R, G, B) and measures each one's high time over fixed windows of PWM_INTERVAL clocks.

---
 rtl/pwm_duty_capture.sv | 91 +++++++++
 tb/tb_pwm_duty_capture.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures the high time of three PWM lines over free-running windows
// of PWM_INTERVAL clocks and reports per-channel duty with a one-cycle valid strobe.
`default_nettype none

module pwm_duty_capture #(
  parameter int PWM_INTERVAL = 1200,
  localparam int CW = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_r,
  input  logic          pwm_g,
  input  logic          pwm_b,
  output logic [CW-1:0] duty_r,
  output logic [CW-1:0] duty_g,
  output logic [CW-1:0] duty_b,
  output logic          duty_valid,
  output logic [2:0]    period_err,
  output logic [CW-1:0] win_cnt
);

  localparam logic [CW-1:0] LAST = CW'(PWM_INTERVAL - 1);

  // Channel index order is {b,g,r} throughout.
  logic [2:0]    meta;
  logic [2:0]    sync;
  logic [2:0]    prev;
  logic [2:0]    rise;
  logic [2:0]    err_next;
  logic [CW-1:0] acc  [3];
  logic [CW-1:0] duty [3];
  logic [1:0]    edg  [3];
  logic          win_end;

  assign rise    = sync & ~prev;
  assign win_end = (win_cnt == LAST);

  // A rise on the closing cycle still belongs to the window being closed.
  always_comb begin
    err_next = '0;
    for (int i = 0; i < 3; i++) begin
      err_next[i] = ({1'b0, edg[i]} + {2'b00, rise[i]}) > 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= '0;
      sync       <= '0;
      prev       <= '0;
      win_cnt    <= '0;
      duty_valid <= 1'b0;
      period_err <= '0;
      for (int i = 0; i < 3; i++) begin
        acc[i]  <= '0;
        duty[i] <= '0;
        edg[i]  <= '0;
      end
    end else begin
      meta       <= {pwm_b, pwm_g, pwm_r};
      sync       <= meta;
      prev       <= sync;
      duty_valid <= 1'b0;
      if (win_end) begin
        win_cnt    <= '0;
        duty_valid <= 1'b1;
        period_err <= err_next;
        for (int i = 0; i < 3; i++) begin
          duty[i] <= acc[i] + {{(CW-1){1'b0}}, sync[i]};
          acc[i]  <= '0;
          edg[i]  <= '0;
        end
      end else begin
        win_cnt <= win_cnt + {{(CW-1){1'b0}}, 1'b1};
        for (int i = 0; i < 3; i++) begin
          acc[i] <= acc[i] + {{(CW-1){1'b0}}, sync[i]};
          if (rise[i] && (edg[i] != 2'd3)) begin
            edg[i] <= edg[i] + 2'd1;
          end
        end
      end
    end
  end

  assign duty_r = duty[0];
  assign duty_g = duty[1];
  assign duty_b = duty[2];

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_capture.sv
// tb_pwm_duty_capture: randomized PWM stimulus checked against a window-sum reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_duty_capture;

  localparam int PI = 1200;
  localparam int CW = $clog2(PI + 1);
  localparam int HN = 4096;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          pwm_r = 1'b0;
  logic          pwm_g = 1'b0;
  logic          pwm_b = 1'b0;
  logic [CW-1:0] duty_r, duty_g, duty_b, win_cnt;
  logic          duty_valid;
  logic [2:0]    period_err;

  int tests = 0;
  int fails = 0;

  pwm_duty_capture #(.PWM_INTERVAL(PI)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_valid(duty_valid),
    .period_err(period_err), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  // Line generator: per==0 means a constant level of (hi!=0); rnd gives coin-flip samples.
  int per [3] = '{0, 0, 0};
  int hi  [3] = '{0, 0, 0};
  int ph  [3] = '{0, 0, 0};
  bit rnd [3] = '{0, 0, 0};
  int t = 0;
  logic [2:0] lv;

  always @(posedge clk) begin
    #1;
    t = t + 1;
    for (int c = 0; c < 3; c++) begin
      if (rnd[c])          lv[c] = 1'($urandom_range(0, 1));
      else if (per[c] == 0) lv[c] = (hi[c] != 0);
      else                 lv[c] = (((t + ph[c]) % per[c]) < hi[c]);
    end
    pwm_r = lv[0];
    pwm_g = lv[1];
    pwm_b = lv[2];
  end

  // Reference model: history of line levels seen at each clock edge since reset release.
  logic [2:0] hist [HN];
  int n = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else begin
      hist[(n + 1) % HN] <= {pwm_b, pwm_g, pwm_r};
      n <= n + 1;
    end
  end

  // Level the block has synchronised by clock edge k: the line as it was two edges earlier.
  function automatic logic sync_at(input int k, input int c);
    if (k < 3) return 1'b0;
    return hist[(k - 2) % HN][c];
  endfunction

  // Expected {err, duty_b, duty_g, duty_r} for the window closed at edge K.
  function automatic logic [3*CW+2:0] model_win(input int K);
    logic [CW-1:0] d [3];
    logic [2:0] e;
    for (int c = 0; c < 3; c++) begin
      int sum = 0;
      int rises = 0;
      for (int k = K - PI + 1; k <= K; k++) begin
        sum += int'(sync_at(k, c));
        if (sync_at(k, c) && !sync_at(k - 1, c)) rises++;
      end
      d[c] = CW'(sum);
      e[c] = (rises > 1);
    end
    return {e, d[2], d[1], d[0]};
  endfunction

  task automatic cfg(input int c, input int p, input int h, input int f, input bit r);
    per[c] = p; hi[c] = h; ph[c] = f; rnd[c] = r;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    t = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < PI + 100; i++) begin
      @(negedge clk);
      cyc++;
      if (duty_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({duty_valid, period_err, duty_b, duty_g, duty_r, win_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h required 0",
               {duty_valid, period_err, duty_b, duty_g, duty_r, win_cnt});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (win_cnt !== CW'(n % PI) || win_cnt !== CW'(10)) begin
      fails++;
      $display("FAIL win_cnt_after_reset: got %0d required %0d", win_cnt, n % PI);
    end
  endtask

  task automatic test_idle();
    int cyc; bit ok;
    for (int c = 0; c < 3; c++) cfg(c, 0, 0, 0, 0);
    apply_reset();
    for (int w = 0; w < 3; w++) begin
      wait_valid(cyc, ok);
      tests++;
      if (!ok || cyc != PI || n % PI != 0) begin
        fails++;
        $display("FAIL idle_valid_period: got %0d cycles (ok=%0d) required %0d", cyc, ok, PI);
      end
      tests++;
      if ({period_err, duty_b, duty_g, duty_r} !== '0 ||
          {period_err, duty_b, duty_g, duty_r} !== model_win(n)) begin
        fails++;
        $display("FAIL idle_duty: got %h required 0", {period_err, duty_b, duty_g, duty_r});
      end
    end
    @(negedge clk);
    tests++;
    if (duty_valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_one_cycle: got %b required 0", duty_valid);
    end
  endtask

  task automatic test_const_high();
    int cyc; bit ok;
    for (int c = 0; c < 3; c++) cfg(c, 0, 0, 0, 0);
    cfg(0, 0, 1, 0, 0);
    apply_reset();
    for (int w = 0; w < 2; w++) begin
      wait_valid(cyc, ok);
      tests++;
      if (!ok || duty_r !== CW'(w == 0 ? PI - 2 : PI) || period_err[0] !== 1'b0 ||
          {period_err, duty_b, duty_g, duty_r} !== model_win(n)) begin
        fails++;
        $display("FAIL const_high_w%0d: got duty_r=%0d err=%b required duty_r=%0d err=0",
                 w, duty_r, period_err, (w == 0 ? PI - 2 : PI));
      end
    end
  endtask

  task automatic test_phase();
    int cyc; bit ok; int h; int f;
    for (int s = 0; s < 3; s++) begin
      h = (s == 0) ? 300 : $urandom_range(1, PI - 1);
      f = (s == 0) ? 517 : $urandom_range(0, PI - 1);
      for (int c = 0; c < 3; c++) cfg(c, 0, 0, 0, 0);
      cfg(1, PI, h, f, 0);
      apply_reset();
      for (int w = 0; w < 2; w++) begin
        wait_valid(cyc, ok);
        tests++;
        if (!ok || {period_err, duty_b, duty_g, duty_r} !== model_win(n)) begin
          fails++;
          $display("FAIL phase_model_h%0d_w%0d: got %h required %h", h, w,
                   {period_err, duty_b, duty_g, duty_r}, model_win(n));
        end
      end
      tests++;
      if (duty_g !== CW'(h) || period_err[1] !== 1'b0) begin
        fails++;
        $display("FAIL phase_steady_ph%0d: got duty_g=%0d err=%b required %0d err=0",
                 f, duty_g, period_err[1], h);
      end
    end
  endtask

  task automatic test_double_edge();
    int cyc; bit ok;
    for (int c = 0; c < 3; c++) cfg(c, 0, 0, 0, 0);
    cfg(2, 600, 150, $urandom_range(0, 599), 0);
    apply_reset();
    for (int w = 0; w < 3; w++) begin
      wait_valid(cyc, ok);
      tests++;
      if (!ok || {period_err, duty_b, duty_g, duty_r} !== model_win(n)) begin
        fails++;
        $display("FAIL double_model_w%0d: got %h required %h", w,
                 {period_err, duty_b, duty_g, duty_r}, model_win(n));
      end
    end
    tests++;
    if (duty_b !== CW'(300) || period_err[2] !== 1'b1) begin
      fails++;
      $display("FAIL double_steady: got duty_b=%0d err=%b required 300 err=1",
               duty_b, period_err[2]);
    end
  endtask

  task automatic test_random();
    int cyc; bit ok; int p;
    p = $urandom_range(2, PI);
    cfg(0, 0, 0, 0, 1);
    cfg(1, p, $urandom_range(0, p), $urandom_range(0, p - 1), 0);
    cfg(2, $urandom_range(2, 50), $urandom_range(1, 10), 0, 0);
    apply_reset();
    for (int w = 0; w < 4; w++) begin
      wait_valid(cyc, ok);
      tests++;
      if (!ok || n % PI != 0 || {period_err, duty_b, duty_g, duty_r} !== model_win(n)) begin
        fails++;
        $display("FAIL random_w%0d: got %h required %h (ok=%0d n=%0d)", w,
                 {period_err, duty_b, duty_g, duty_r}, model_win(n), ok, n);
      end
      tests++;
      if (duty_r > CW'(PI) || duty_g > CW'(PI) || duty_b > CW'(PI)) begin
        fails++;
        $display("FAIL random_range_w%0d: got %0d/%0d/%0d required <= %0d", w,
                 duty_r, duty_g, duty_b, PI);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; bit found;
    cfg(0, 0, 1, 0, 0);
    cfg(1, PI, 600, $urandom_range(0, PI - 1), 0);
    cfg(2, 0, 0, 0, 0);
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 3 * PI && !found; i++) begin
      @(negedge clk);
      if (n > PI && win_cnt == CW'(700)) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL mid_reach_700: got win_cnt=%0d required 700", win_cnt);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({duty_valid, period_err, duty_b, duty_g, duty_r, win_cnt} !== '0) begin
      fails++;
      $display("FAIL mid_reset_immediate: got %h required 0",
               {duty_valid, period_err, duty_b, duty_g, duty_r, win_cnt});
    end
    repeat (5) @(negedge clk);
    t = 0;
    rst_n = 1'b1;
    wait_valid(cyc, ok);
    tests++;
    if (!ok || cyc != PI || duty_r !== CW'(PI - 2) ||
        {period_err, duty_b, duty_g, duty_r} !== model_win(n)) begin
      fails++;
      $display("FAIL mid_first_window: got cyc=%0d %h required cyc=%0d %h", cyc,
               {period_err, duty_b, duty_g, duty_r}, PI, model_win(n));
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_const_high();
    test_phase();
    test_double_edge();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
